array_access_arbiter: RTL and testbench
=======================================

# array_access_arbiter

Two-requester access controller for the `array_behavioral` memory (separate write and read ports, registered read with 1-cycle latency). It accepts valid/ready requests from two clients and drives the memory's write and read ports. A write and a read from different clients issue in the same cycle. Same-port conflicts use round-robin. A read/write collision on the same address is resolved write-first. Read data is returned to the owning requester one cycle after acceptance.

## Interface
Parameters:
- `WIDTH`, 8, data word width
- `DEPTH`, 4, memory words; `ADDR = $clog2(DEPTH)` derived locally

Ports (n = 0, 1):
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `reqn_valid`  in  1  request present
- `reqn_ready`  out  1  request granted this cycle (combinational)
- `reqn_write`  in  1  1 = write, 0 = read
- `reqn_addr`  in  ADDR  target word
- `reqn_data`  in  WIDTH  write data
- `rspn_valid`  out  1  read data for requester n is on `rsp_data`
- `rsp_data`  out  WIDTH  read data, shared by both requesters
- `mem_write_en`  out  1  memory write enable
- `mem_write_addr`  out  ADDR  memory write address
- `mem_write_data`  out  WIDTH  memory write data
- `mem_read_addr`  out  ADDR  memory read address
- `mem_read_data`  in  WIDTH  memory registered read data

## Operation
- **Handshake.** A request is accepted at a rising edge where `reqn_valid & reqn_ready & rst_n`. While valid, the requester holds `write`, `addr` and `data` stable until accepted. `ready` is never asserted without `valid`.
- **Port classes.** Each cycle has at most one write grant and at most one read grant.
- **Same-class conflict** (both requesters valid, both writes or both reads):
  - Grant the requester selected by the priority pointer `prio` (0 → req0, 1 → req1).
  - `prio` then flips to the loser.
  - With no conflict, `prio` is unchanged.
- **Mixed classes** (one read, one write, different addresses): both are granted in the same cycle.
- **Read/write collision** (one read, one write, same address):
  - Grant only the write; the read's `ready` is 0.
  - The read is granted the next cycle and returns the newly written data.
  - `prio` is unchanged.
- **Memory drive.**
  - `mem_write_en` equals the write grant. `mem_write_addr` and `mem_write_data` come from the granted writer, or 0 when there is no write grant.
  - `mem_read_addr` comes from the granted reader, or 0 when idle.
- **Response tracking.**
  - A registered pair `rsp_pend` (valid bit) and `rsp_id` (requester index) is loaded on each read acceptance.
  - `rspn_valid = rsp_pend & (rsp_id == n)`.
  - `rsp_data = mem_read_data`, passed through.
- **Reset** (`rst_n` low at an edge):
  - `prio = 0`, `rsp_pend = 0`, `rsp_id = 0`.
  - While `rst_n` is low, all grants are forced to 0. As a result `reqn_ready = 0`, `mem_write_en = 0`, and all `mem_*` address/data outputs are 0.
- **Reset mid-operation.** A read accepted in cycle N followed by `rst_n` low at edge N+1 produces no response; the pending entry is discarded. Any write accepted before reset has already reached memory.

## Timing
- Grant, `ready` and `mem_*` outputs are combinational from requests, `prio` and `rst_n`. Zero-cycle issue.
- Read latency: accept at edge N → `rspn_valid = 1` and valid `rsp_data` during cycle N+1, for exactly one cycle per read.
- Back-to-back reads by one requester sustain 1 read/cycle, giving a continuous `rspn_valid`.
- Write is committed at the accept edge. A read accepted in a later cycle observes it.
- Fairness: under continuous same-class contention, grants alternate 0,1,0,1… starting with req0 after reset. No requester waits more than 1 cycle per conflict; a read stalled by a collision waits at most 1 further cycle per colliding write.

## Structure
- Shared package `array_ctrl_pkg`:
  - requester-id constants `REQ0 = 1'b0`, `REQ1 = 1'b1`
  - op encoding `OP_READ = 1'b0`, `OP_WRITE = 1'b1`
- Sub-module `rr_grant2`: combinational 2-way grant from (`valid0`, `valid1`, `prio`) → (`gnt0`, `gnt1`, `conflict`). Instanced once for the write class and once for the read class.
- The top holds `prio`, the response register, collision masking and the memory muxes.

## Test plan
- **Reset:** `rst_n` = 0 for 2 cycles with both requesters valid → `reqn_ready` = 0, `mem_write_en` = 0, `rspn_valid` = 0. After release, req0 is granted first on a write conflict.
- **Single-client fill/readback** (DUT wired to `array_behavioral`): req0 writes addr i = 0..3 with data i*8'h11, then reads 0..3 back-to-back → `rsp0_valid` high for 4 consecutive cycles with data 00, 11, 22, 33, each one cycle after its accept. `rsp1_valid` stays 0.
- **Write contention:** both requesters continuously write (req0 addr0 = 8'hA0, req1 addr1 = 8'hB1) for 4 cycles → grants req0, req1, req0, req1. Readback gives A0 and B1.
- **Mixed, different addresses:** req0 reads addr1 while req1 writes 8'h5C to addr3 in the same cycle → both `ready` = 1. Next cycle `rsp0_valid` = 1 with the old addr1 data. A later read of addr3 returns 5C.
- **Collision:** req0 reads addr2 while req1 writes 8'hAB to addr2 → cycle N: `req1_ready` = 1, `req0_ready` = 0. Cycle N+1: `req0_ready` = 1. Cycle N+2: `rsp0_valid` = 1, `rsp_data` = 8'hAB.
- **Reset mid-read:** req1 read accepted at edge N, `rst_n` low at edge N+1 → `rsp1_valid` never asserts and `prio` returns to 0.

Source files
------------

// File: rtl/array_ctrl_pkg.sv
// ============================================================================
// Module  : array_ctrl_pkg
// Brief   : Shared constants for the two-requester array access controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package array_ctrl_pkg;

    localparam logic REQ0     = 1'b0;
    localparam logic REQ1     = 1'b1;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_grant2.sv
// ============================================================================
// Module  : rr_grant2
// Brief   : Combinational two-way round-robin grant; prio selects the winner
//           only when both requesters are valid.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_grant2 (
    input  logic valid0,
    input  logic valid1,
    input  logic prio,
    output logic gnt0,
    output logic gnt1,
    output logic conflict
);

    assign conflict = valid0 & valid1;
    assign gnt0     = valid0 & (~valid1 | ~prio);
    assign gnt1     = valid1 & (~valid0 |  prio);

endmodule

`default_nettype wire

// File: rtl/array_access_arbiter.sv
// ============================================================================
// Module  : array_access_arbiter
// Brief   : Two-client valid/ready front end for a 1R1W memory with a
//           registered read; round-robin per port, write-first on collision.
// Revision: 1.0
// ============================================================================
`default_nettype none

module array_access_arbiter #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int ADDR  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_write,
    input  logic [ADDR-1:0]  req0_addr,
    input  logic [WIDTH-1:0] req0_data,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_write,
    input  logic [ADDR-1:0]  req1_addr,
    input  logic [WIDTH-1:0] req1_data,

    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp_data,

    output logic             mem_write_en,
    output logic [ADDR-1:0]  mem_write_addr,
    output logic [WIDTH-1:0] mem_write_data,
    output logic [ADDR-1:0]  mem_read_addr,
    input  logic [WIDTH-1:0] mem_read_data
);

    import array_ctrl_pkg::*;

    logic            prio;
    logic            rsp_pend;
    logic            rsp_id;

    logic            wr_v0, wr_v1, rd_v0, rd_v1;
    logic            wr_g0, wr_g1, wr_conf;
    logic            rd_g0, rd_g1, rd_conf;
    logic            rd_ok0, rd_ok1;
    logic            wr_any, rd_any, collide;
    logic [ADDR-1:0] rd_cand_addr;

    // Holding rst_n low suppresses every request before arbitration.
    assign wr_v0 = rst_n & req0_valid & (req0_write == OP_WRITE);
    assign wr_v1 = rst_n & req1_valid & (req1_write == OP_WRITE);
    assign rd_v0 = rst_n & req0_valid & (req0_write == OP_READ);
    assign rd_v1 = rst_n & req1_valid & (req1_write == OP_READ);

    rr_grant2 u_wr_grant (
        .valid0   (wr_v0),
        .valid1   (wr_v1),
        .prio     (prio),
        .gnt0     (wr_g0),
        .gnt1     (wr_g1),
        .conflict (wr_conf)
    );

    rr_grant2 u_rd_grant (
        .valid0   (rd_v0),
        .valid1   (rd_v1),
        .prio     (prio),
        .gnt0     (rd_g0),
        .gnt1     (rd_g1),
        .conflict (rd_conf)
    );

    assign wr_any       = wr_g0 | wr_g1;
    assign rd_cand_addr = rd_g1 ? req1_addr : req0_addr;

    // Same-address read waits a cycle so it observes the committed write.
    assign collide = wr_any & (rd_g0 | rd_g1) & (mem_write_addr == rd_cand_addr);
    assign rd_ok0  = rd_g0 & ~collide;
    assign rd_ok1  = rd_g1 & ~collide;
    assign rd_any  = rd_ok0 | rd_ok1;

    assign req0_ready = wr_g0 | rd_ok0;
    assign req1_ready = wr_g1 | rd_ok1;

    always_comb begin
        mem_write_en   = wr_any;
        mem_write_addr = '0;
        mem_write_data = '0;
        mem_read_addr  = '0;
        if (wr_g1) begin
            mem_write_addr = req1_addr;
            mem_write_data = req1_data;
        end else if (wr_g0) begin
            mem_write_addr = req0_addr;
            mem_write_data = req0_data;
        end
        if (rd_ok1) begin
            mem_read_addr = req1_addr;
        end else if (rd_ok0) begin
            mem_read_addr = req0_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio     <= 1'b0;
            rsp_pend <= 1'b0;
            rsp_id   <= REQ0;
        end else begin
            if (wr_conf | rd_conf) begin
                prio <= ~prio;
            end
            rsp_pend <= rd_any;
            if (rd_any) begin
                rsp_id <= rd_ok1 ? REQ1 : REQ0;
            end
        end
    end

    // A pending response is dropped as soon as reset is asserted.
    assign rsp0_valid = rst_n & rsp_pend & (rsp_id == REQ0);
    assign rsp1_valid = rst_n & rsp_pend & (rsp_id == REQ1);
    assign rsp_data   = mem_read_data;

endmodule

`default_nettype wire

// File: tb/tb_array_access_arbiter.sv
// ============================================================================
// Module  : tb_array_access_arbiter
// Brief   : Self-checking bench with a behavioural 1R1W memory and a response
//           scoreboard for array_access_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_array_access_arbiter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int ADDR  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req0_ready, req0_write;
    logic [ADDR-1:0]  req0_addr;
    logic [WIDTH-1:0] req0_data;
    logic             req1_valid, req1_ready, req1_write;
    logic [ADDR-1:0]  req1_addr;
    logic [WIDTH-1:0] req1_data;
    logic             rsp0_valid, rsp1_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             mem_write_en;
    logic [ADDR-1:0]  mem_write_addr, mem_read_addr;
    logic [WIDTH-1:0] mem_write_data;
    logic [WIDTH-1:0] mem_read_data = '0;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH:0]   exp_q [$];
    int               n_checks = 0;
    int               n_fail   = 0;

    always #5 clk = ~clk;

    array_access_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_write     (req0_write),
        .req0_addr      (req0_addr),
        .req0_data      (req0_data),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_write     (req1_write),
        .req1_addr      (req1_addr),
        .req1_data      (req1_data),
        .rsp0_valid     (rsp0_valid),
        .rsp1_valid     (rsp1_valid),
        .rsp_data       (rsp_data),
        .mem_write_en   (mem_write_en),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_read_addr  (mem_read_addr),
        .mem_read_data  (mem_read_data)
    );

    // Behavioural memory: write at the edge, registered read of old contents.
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_write_addr] <= mem_write_data;
        mem_read_data <= mem[mem_read_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every response popped against the expectation queued at issue.
    always @(negedge clk) begin
        if (rsp0_valid || rsp1_valid) begin
            chk("rsp_onehot", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                logic [WIDTH:0] e;
                e = exp_q.pop_front();
                chk("rsp_id", {31'd0, rsp1_valid}, {31'd0, e[WIDTH]});
                chk("rsp_data", {24'd0, rsp_data}, {24'd0, e[WIDTH-1:0]});
            end
        end
    end

    task automatic drive(input logic v0, input logic w0, input int a0, input int d0,
                         input logic v1, input logic w1, input int a1, input int d1);
        req0_valid = v0; req0_write = w0; req0_addr = ADDR'(a0); req0_data = WIDTH'(d0);
        req1_valid = v1; req1_write = w1; req1_addr = ADDR'(a1); req1_data = WIDTH'(d1);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input logic id, input int d);
        exp_q.push_back({id, WIDTH'(d)});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        // Reset held with both clients requesting writes.
        drive(1, 1, 0, 'hA0, 1, 1, 1, 'hB1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
            chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
            chk("rst_wen", {31'd0, mem_write_en}, 32'd0);
            chk("rst_waddr", {30'd0, mem_write_addr}, 32'd0);
            chk("rst_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
            next_cycle();
        end
        rst_n = 1'b1;

        // Write contention alternates starting with req0.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("wc_ready0", {31'd0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("wc_ready1", {31'd0, req1_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
            chk("wc_wdata", {24'd0, mem_write_data}, (k % 2 == 0) ? 32'hA0 : 32'hB1);
            next_cycle();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        push(1'b0, 'hA0);
        @(negedge clk);
        chk("rb_ready_a", {31'd0, req0_ready}, 32'd1);
        next_cycle();
        drive(1, 0, 1, 0, 0, 0, 0, 0);
        push(1'b0, 'hB1);
        @(negedge clk);
        chk("rb_rsp_a", {31'd0, rsp0_valid}, 32'd1);
        next_cycle();
        idle();
        @(negedge clk);
        chk("rb_rsp_b", {31'd0, rsp0_valid}, 32'd1);
        next_cycle();

        // Single-client fill then back-to-back readback.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, i, i * 'h11, 0, 0, 0, 0);
            @(negedge clk);
            chk("fill_ready", {31'd0, req0_ready}, 32'd1);
            next_cycle();
        end
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                drive(1, 0, i, 0, 0, 0, 0, 0);
                push(1'b0, i * 'h11);
            end else begin
                idle();
            end
            @(negedge clk);
            chk("b2b_rsp0", {31'd0, rsp0_valid}, (i == 0) ? 32'd0 : 32'd1);
            chk("b2b_rsp1", {31'd0, rsp1_valid}, 32'd0);
            next_cycle();
        end
        @(negedge clk);
        chk("b2b_done", {31'd0, rsp0_valid}, 32'd0);
        next_cycle();

        // Mixed classes, different addresses: both granted together.
        drive(1, 0, 1, 0, 1, 1, 3, 'h5C);
        push(1'b0, 'h11);
        @(negedge clk);
        chk("mix_ready0", {31'd0, req0_ready}, 32'd1);
        chk("mix_ready1", {31'd0, req1_ready}, 32'd1);
        next_cycle();
        drive(0, 0, 0, 0, 1, 0, 3, 0);
        push(1'b1, 'h5C);
        @(negedge clk);
        chk("mix_rsp0", {31'd0, rsp0_valid}, 32'd1);
        next_cycle();
        idle();
        @(negedge clk);
        chk("mix_rsp1", {31'd0, rsp1_valid}, 32'd1);
        next_cycle();

        // Same-address read/write collision resolves write-first.
        drive(1, 0, 2, 0, 1, 1, 2, 'hAB);
        @(negedge clk);
        chk("col_ready1", {31'd0, req1_ready}, 32'd1);
        chk("col_ready0", {31'd0, req0_ready}, 32'd0);
        next_cycle();
        drive(1, 0, 2, 0, 0, 0, 0, 0);
        push(1'b0, 'hAB);
        @(negedge clk);
        chk("col_ready0_n1", {31'd0, req0_ready}, 32'd1);
        next_cycle();
        idle();
        @(negedge clk);
        chk("col_rsp0", {31'd0, rsp0_valid}, 32'd1);
        next_cycle();

        // Move prio to req1, then reset with a read in flight.
        drive(1, 1, 0, 'h01, 1, 1, 0, 'h02);
        @(negedge clk);
        chk("pr_ready0", {31'd0, req0_ready}, 32'd1);
        next_cycle();
        drive(0, 0, 0, 0, 1, 0, 1, 0);
        @(negedge clk);
        chk("mr_ready1", {31'd0, req1_ready}, 32'd1);
        next_cycle();
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_rsp1_rst", {31'd0, rsp1_valid}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_rsp1_after", {31'd0, rsp1_valid}, 32'd0);
        next_cycle();
        drive(1, 1, 0, 'h03, 1, 1, 1, 'h04);
        @(negedge clk);
        chk("mr_prio_ready0", {31'd0, req0_ready}, 32'd1);
        chk("mr_prio_ready1", {31'd0, req1_ready}, 32'd0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
